microwave_timer: RTL

Countdown timer stage of the microwave controller. Accepts keypad digits as a four-digit BCD MM:SS setting and counts it down once per second while the control block holds `mag_on` high. It produces the `timer_done` level that the control block consumes to drop the magnetron. It also drives the BCD digits to the display stage.

---
 rtl/microwave_timer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/microwave_timer.sv
// rtl/microwave_timer.sv - MM:SS BCD countdown timer for the microwave controller
//
// Purpose: collects keypad digits into a four-digit BCD MM:SS setting and
// counts it down once per TICK_DIV clocks while mag_on is high. timer_done
// tells the control block to drop the magnetron.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   digit_in     keypad digit (BCD 0-9)
//   digit_valid  one-cycle strobe qualifying digit_in
//   clearn       synchronous clear, active low
//   mag_on       magnetron enable, countdown runs only while high
//   min_tens, min_ones, sec_tens, sec_ones  current time, BCD
//   timer_done   level, high once a countdown has reached 00:00
//   running      high while counting
module microwave_timer #(
  parameter int TICK_DIV = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit_in,
  input  logic       digit_valid,
  input  logic       clearn,
  input  logic       mag_on,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       timer_done,
  output logic       running
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, SET, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [15:0]   time_q, time_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   time_dec;
  logic [15:0]   time_shift;
  logic          digit_ok;

  // One-second BCD decrement. Seconds-tens borrows to 5 so the minutes roll
  // over correctly, while entered tens of 6-9 still just count down.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [3:0] mt, mo, st, so;
    mt = t[15:12];
    mo = t[11:8];
    st = t[7:4];
    so = t[3:0];
    if (so != 4'd0) begin
      so = so - 4'd1;
    end else begin
      so = 4'd9;
      if (st != 4'd0) begin
        st = st - 4'd1;
      end else begin
        st = 4'd5;
        if (mo != 4'd0) begin
          mo = mo - 4'd1;
        end else begin
          mo = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  assign time_dec   = bcd_dec(time_q);
  assign time_shift = {time_q[11:0], digit_in};
  assign digit_ok   = digit_valid && (digit_in <= 4'd9) && (state_q != RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      time_q  <= '0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      presc_q <= presc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    presc_d = '0;
    if (!clearn) begin
      state_d = IDLE;
      time_d  = '0;
    end else if (digit_ok) begin
      time_d  = time_shift;
      state_d = (time_shift != 16'd0) ? SET : IDLE;
    end else begin
      case (state_q)
        IDLE: if (mag_on) state_d = DONE;
        SET:  if (mag_on) state_d = RUN;
        RUN: begin
          if (!mag_on) begin
            // Pause: the partial second is discarded.
            state_d = SET;
          end else if (presc_q == PRESC_MAX) begin
            time_d = time_dec;
            if (time_dec == 16'd0) state_d = DONE;
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  assign min_tens   = time_q[15:12];
  assign min_ones   = time_q[11:8];
  assign sec_tens   = time_q[7:4];
  assign sec_ones   = time_q[3:0];
  assign timer_done = (state_q == DONE);
  assign running    = (state_q == RUN);

endmodule
